// File: rtl/downscale_pkg.sv
// Shared types and constants for the downscale engine: FSM state encoding, output window
// defaults and the Q8.8 fraction width.
package downscale_pkg;

    localparam logic [15:0] OUT_BASE_DEF  = 16'h8000;
    localparam logic [15:0] OUT_LIMIT_DEF = 16'hFFEF;
    localparam int unsigned FRAC_W        = 8;
    localparam logic [7:0]  MODE_NEAREST  = 8'h02;

    typedef enum logic [3:0] {
        StIdle,
        StRdA,
        StRdB,
        StRdC,
        StRdD,
        StCap,
        StCalc,
        StWr,
        StHold
    } state_e;

    // Linear source address; the product is deliberately truncated to 16 bits.
    function automatic logic [15:0] pix_addr(input logic [15:0] row, input logic [15:0] col,
                                             input logic [15:0] width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/bilerp_core.sv
// Combinational bilinear blend of four 8-bit neighbours with Q0.8 weights, rounded to nearest.
module bilerp_core
    import downscale_pkg::*;
(
    input  logic [7:0]        p00,
    input  logic [7:0]        p01,
    input  logic [7:0]        p10,
    input  logic [7:0]        p11,
    input  logic [FRAC_W-1:0] frac_x,
    input  logic [FRAC_W-1:0] frac_y,
    output logic [7:0]        result
);

    localparam logic [FRAC_W:0] ONE   = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [23:0]     ROUND = 24'h8000;

    logic [FRAC_W:0] wx0;
    logic [FRAC_W:0] wy0;
    logic [15:0]     top;
    logic [15:0]     bot;
    logic [23:0]     acc;

    // Row blends peak at 255*256, so 16 bits cannot overflow; acc peaks below 2^24.
    always_comb begin
        wx0    = ONE - {1'b0, frac_x};
        wy0    = ONE - {1'b0, frac_y};
        top    = 16'(p00) * 16'(wx0) + 16'(p01) * 16'(frac_x);
        bot    = 16'(p10) * 16'(wx0) + 16'(p11) * 16'(frac_x);
        acc    = 24'(top) * 24'(wy0) + 24'(bot) * 24'(frac_y) + ROUND;
        result = 8'(acc >> (2 * FRAC_W));
    end

endmodule

// File: rtl/downscale_engine.sv
// Frame rescaler: walks a Q16.8 source grid, fetches one (nearest) or four (bilinear)
// neighbours per output pixel and writes results to a linear output buffer.
module downscale_engine
    import downscale_pkg::*;
#(
    parameter logic [15:0] OUT_BASE  = OUT_BASE_DEF,
    parameter logic [15:0] OUT_LIMIT = OUT_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        start_pulse,
    input  logic        step_mode,
    input  logic        step_pulse,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [15:0] cfg_scale,
    input  logic [7:0]  cfg_mode,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [15:0] scale_q, scale_d;
    logic [7:0]  mode_q, mode_d;
    logic [23:0] fx_q, fx_d;
    logic [23:0] fy_q, fy_d;
    logic [15:0] out_addr_q, out_addr_d;
    logic [7:0]  p00_q, p00_d;
    logic [7:0]  p01_q, p01_d;
    logic [7:0]  p10_q, p10_d;
    logic [7:0]  p11_q, p11_d;
    logic [7:0]  result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        nearest;
    logic        degenerate;
    logic [15:0] w_m1, h_m1;
    logic [15:0] x0, y0, x1, y1;
    logic [23:0] fx_step, fy_step;
    logic        x_wrap, y_over, out_full, frame_end;
    logic [7:0]  lerp_result;

    bilerp_core u_bilerp_core (
        .p00    (p00_q),
        .p01    (p01_q),
        .p10    (p10_q),
        .p11    (p11_q),
        .frac_x (fx_q[FRAC_W-1:0]),
        .frac_y (fy_q[FRAC_W-1:0]),
        .result (lerp_result)
    );

    always_comb begin
        nearest    = (mode_q & MODE_NEAREST) != 8'h00;
        degenerate = (width_q == 16'd0) || (height_q == 16'd0) || (scale_q == 16'd0);
        w_m1       = width_q - 16'd1;
        h_m1       = height_q - 16'd1;
        x0         = fx_q[23:FRAC_W];
        y0         = fy_q[23:FRAC_W];
        x1         = (x0 >= w_m1) ? w_m1 : x0 + 16'd1;
        y1         = (y0 >= h_m1) ? h_m1 : y0 + 16'd1;
        fx_step    = fx_q + {8'h00, scale_q};
        fy_step    = fy_q + {8'h00, scale_q};
        x_wrap     = fx_step[23:FRAC_W] > w_m1;
        y_over     = fy_step[23:FRAC_W] > h_m1;
        // out_addr_q at the limit means the write in flight is the last one that fits.
        out_full   = out_addr_q >= OUT_LIMIT;
        frame_end  = (x_wrap && y_over) || out_full;
    end

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        scale_d    = scale_q;
        mode_d     = mode_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        out_addr_d = out_addr_q;
        p00_d      = p00_q;
        p01_d      = p01_q;
        p10_d      = p10_q;
        p11_d      = p11_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;

        case (state_q)
            StIdle: begin
                if (start_pulse) begin
                    width_d    = cfg_width;
                    height_d   = cfg_height;
                    scale_d    = cfg_scale;
                    mode_d     = cfg_mode;
                    fx_d       = 24'h0;
                    fy_d       = 24'h0;
                    out_addr_d = OUT_BASE;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = StRdA;
                end
            end
            StRdA: begin
                if (degenerate) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = pix_addr(y0, x0, width_q);
                    state_d  = nearest ? StCap : StRdB;
                end
            end
            // Each read state captures the data returned for the previous one.
            StRdB: begin
                p00_d    = mem_rdata;
                mem_re   = 1'b1;
                mem_addr = pix_addr(y0, x1, width_q);
                state_d  = StRdC;
            end
            StRdC: begin
                p01_d    = mem_rdata;
                mem_re   = 1'b1;
                mem_addr = pix_addr(y1, x0, width_q);
                state_d  = StRdD;
            end
            StRdD: begin
                p10_d    = mem_rdata;
                mem_re   = 1'b1;
                mem_addr = pix_addr(y1, x1, width_q);
                state_d  = StCap;
            end
            StCap: begin
                if (nearest) begin
                    p00_d = mem_rdata;
                end else begin
                    p11_d = mem_rdata;
                end
                state_d = StCalc;
            end
            StCalc: begin
                result_d = nearest ? p00_q : lerp_result;
                state_d  = StWr;
            end
            StWr: begin
                mem_we     = 1'b1;
                mem_addr   = out_addr_q;
                mem_wdata  = result_q;
                out_addr_d = out_addr_q + 16'd1;
                if (x_wrap) begin
                    fx_d = 24'h0;
                    fy_d = fy_step;
                end else begin
                    fx_d = fx_step;
                end
                if (frame_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (step_mode) begin
                    state_d = StHold;
                end else begin
                    state_d = StRdA;
                end
            end
            StHold: begin
                if (step_pulse) begin
                    state_d = StRdA;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q    <= StIdle;
            width_q    <= 16'h0;
            height_q   <= 16'h0;
            scale_q    <= 16'h0;
            mode_q     <= 8'h0;
            fx_q       <= 24'h0;
            fy_q       <= 24'h0;
            out_addr_q <= 16'h0;
            p00_q      <= 8'h0;
            p01_q      <= 8'h0;
            p10_q      <= 8'h0;
            p11_q      <= 8'h0;
            result_q   <= 8'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            scale_q    <= scale_d;
            mode_q     <= mode_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            out_addr_q <= out_addr_d;
            p00_q      <= p00_d;
            p01_q      <= p01_d;
            p10_q      <= p10_d;
            p11_q      <= p11_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_downscale_engine.sv
// Directed bench for downscale_engine: expected writes are queued at start and popped as
// the DUT writes; a second instance covers a non-default output base near the limit.
module tb_downscale_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aclr, start_pulse, start_l, step_mode, step_pulse;
    logic [15:0] cfg_width, cfg_height, cfg_scale;
    logic [7:0]  cfg_mode;
    logic        mem_re, mem_we, busy, done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_re_l, mem_we_l, busy_l, done_l;
    logic [15:0] mem_addr_l;
    logic [7:0]  mem_wdata_l, mem_rdata_l;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_q[$];
    logic [23:0] exp_l_q[$];
    logic [7:0]  bil_exp [16];

    int tests = 0, fails = 0;
    int cyc = 0, last_we = -1;
    bit gap_on = 1'b0;
    int re_cnt = 0, we_cnt = 0, we_cnt_l = 0, both_cnt = 0;

    downscale_engine dut (
        .clk         (clk),
        .aclr        (aclr),
        .start_pulse (start_pulse),
        .step_mode   (step_mode),
        .step_pulse  (step_pulse),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_scale   (cfg_scale),
        .cfg_mode    (cfg_mode),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done)
    );

    downscale_engine #(.OUT_BASE(16'hFFEE)) dut_l (
        .clk         (clk),
        .aclr        (aclr),
        .start_pulse (start_l),
        .step_mode   (step_mode),
        .step_pulse  (step_pulse),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_scale   (cfg_scale),
        .cfg_mode    (cfg_mode),
        .mem_re      (mem_re_l),
        .mem_we      (mem_we_l),
        .mem_addr    (mem_addr_l),
        .mem_wdata   (mem_wdata_l),
        .mem_rdata   (mem_rdata_l),
        .busy        (busy_l),
        .done        (done_l)
    );

    always @(posedge clk) begin
        if (mem_re)   mem_rdata   <= mem[mem_addr];
        if (mem_re_l) mem_rdata_l <= mem[mem_addr_l];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any write seen there.
    task automatic tick();
        logic [23:0] e;
        @(negedge clk);
        cyc++;
        if (mem_re) re_cnt++;
        if ((mem_re && mem_we) || (mem_re_l && mem_we_l)) both_cnt++;
        if (mem_we) begin
            we_cnt++;
            if (gap_on) begin
                if (last_we >= 0) check("we_gap", 32'(cyc - last_we), 32'd7);
                last_we = cyc;
            end
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", {16'h0, mem_addr}, {16'h0, e[23:8]});
                check("wr_data", {24'h0, mem_wdata}, {24'h0, e[7:0]});
            end
        end
        if (mem_we_l) begin
            we_cnt_l++;
            check("lim_wr_expected", 32'(exp_l_q.size() != 0), 32'd1);
            if (exp_l_q.size() != 0) begin
                e = exp_l_q.pop_front();
                check("lim_wr_addr", {16'h0, mem_addr_l}, {16'h0, e[23:8]});
                check("lim_wr_data", {24'h0, mem_wdata_l}, {24'h0, e[7:0]});
            end
        end
    endtask

    task automatic run_start(input logic [15:0] w, input logic [15:0] h, input logic [15:0] s,
                             input logic [7:0] m);
        cfg_width   = w;
        cfg_height  = h;
        cfg_scale   = s;
        cfg_mode    = m;
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit sel);
        int n;
        n = 0;
        while (((sel ? done_l : done) !== 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(sel ? done_l : done), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    endtask

    task automatic load_2x2();
        mem[0] = 8'd0;
        mem[1] = 8'd100;
        mem[2] = 8'd100;
        mem[3] = 8'd200;
    endtask

    task automatic push_half();
        exp_q.push_back({16'h8000, 8'd0});
        exp_q.push_back({16'h8001, 8'd2});
        exp_q.push_back({16'h8002, 8'd8});
        exp_q.push_back({16'h8003, 8'd10});
    endtask

    task automatic push_bilinear();
        for (int i = 0; i < 16; i++) exp_q.push_back({16'h8000 + 16'(i), bil_exp[i]});
    endtask

    initial begin
        int re0;
        int we0;
        aclr        = 1'b0;
        start_pulse = 1'b0;
        start_l     = 1'b0;
        step_mode   = 1'b0;
        step_pulse  = 1'b0;
        cfg_width   = 16'd0;
        cfg_height  = 16'd0;
        cfg_scale   = 16'd0;
        cfg_mode    = 8'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        bil_exp = '{8'd0,   8'd50,  8'd100, 8'd100,
                    8'd50,  8'd100, 8'd150, 8'd150,
                    8'd100, 8'd150, 8'd200, 8'd200,
                    8'd100, 8'd150, 8'd200, 8'd200};

        repeat (3) tick();
        check_reset_outputs();
        aclr = 1'b1;
        tick();

        // Nearest-mode halving of a 4x4 ramp.
        load_ramp();
        push_half();
        re0 = re_cnt;
        run_start(16'd4, 16'd4, 16'h0200, 8'h02);
        check("half_busy", 32'(busy), 32'd1);
        wait_done("half_done", 200, 1'b0);
        check("half_idle", 32'(busy), 32'd0);
        check("half_drained", 32'(exp_q.size()), 32'd0);
        check("half_reads", 32'(re_cnt - re0), 32'd4);

        // Bilinear 2x upscale of a 2x2 source.
        load_2x2();
        push_bilinear();
        gap_on  = 1'b1;
        last_we = -1;
        re0     = re_cnt;
        run_start(16'd2, 16'd2, 16'h0080, 8'h00);
        wait_done("bil_done", 400, 1'b0);
        gap_on = 1'b0;
        check("bil_drained", 32'(exp_q.size()), 32'd0);
        check("bil_reads", 32'(re_cnt - re0), 32'd64);

        // Single-step: one write, then HOLD until each step_pulse.
        load_ramp();
        step_mode = 1'b1;
        push_half();
        we0 = we_cnt;
        run_start(16'd4, 16'd4, 16'h0200, 8'h02);
        for (int n = 0; n < 50 && we_cnt == we0; n++) tick();
        check("step_first_wr", 32'(we_cnt - we0), 32'd1);
        re0 = re_cnt;
        we0 = we_cnt;
        repeat (50) tick();
        check("hold_no_rd", 32'(re_cnt - re0), 32'd0);
        check("hold_no_wr", 32'(we_cnt - we0), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            we0        = we_cnt;
            step_pulse = 1'b1;
            tick();
            step_pulse = 1'b0;
            repeat (20) tick();
            check("step_one_wr", 32'(we_cnt - we0), 32'd1);
        end
        check("step_done", 32'(done), 32'd1);
        check("step_drained", 32'(exp_q.size()), 32'd0);
        step_mode = 1'b0;

        // Zero width: done the cycle after start, no memory traffic.
        re0 = re_cnt;
        we0 = we_cnt;
        run_start(16'd0, 16'd4, 16'h0100, 8'h02);
        check("degen_busy", 32'(busy), 32'd1);
        check("degen_done_clr", 32'(done), 32'd0);
        tick();
        check("degen_done", 32'(done), 32'd1);
        check("degen_idle", 32'(busy), 32'd0);
        repeat (3) tick();
        check("degen_no_rd", 32'(re_cnt - re0), 32'd0);
        check("degen_no_wr", 32'(we_cnt - we0), 32'd0);

        // A second start mid-frame must not restart or alter the frame.
        load_ramp();
        push_half();
        run_start(16'd4, 16'd4, 16'h0200, 8'h02);
        repeat (5) tick();
        run_start(16'd4, 16'd4, 16'h0100, 8'h02);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done("restart_done", 200, 1'b0);
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // Output window ends at FFEF: only two pixels fit from base FFEE.
        exp_l_q.push_back({16'hFFEE, 8'd0});
        exp_l_q.push_back({16'hFFEF, 8'd1});
        we0        = we_cnt_l;
        cfg_width  = 16'd4;
        cfg_height = 16'd4;
        cfg_scale  = 16'h0100;
        cfg_mode   = 8'h02;
        start_l    = 1'b1;
        tick();
        start_l = 1'b0;
        wait_done("lim_done", 200, 1'b1);
        check("lim_writes", 32'(we_cnt_l - we0), 32'd2);
        check("lim_idle", 32'(busy_l), 32'd0);
        check("lim_drained", 32'(exp_l_q.size()), 32'd0);

        // Reset in the middle of a bilinear frame, then a clean full rerun.
        load_2x2();
        push_bilinear();
        we0 = we_cnt;
        run_start(16'd2, 16'd2, 16'h0080, 8'h00);
        for (int n = 0; n < 100 && (we_cnt - we0) < 3; n++) tick();
        tick();
        tick();
        #2 aclr = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        repeat (3) tick();
        aclr = 1'b1;
        tick();
        push_bilinear();
        gap_on  = 1'b1;
        last_we = -1;
        re0     = re_cnt;
        run_start(16'd2, 16'd2, 16'h0080, 8'h00);
        wait_done("rerun_done", 400, 1'b0);
        gap_on = 1'b0;
        check("rerun_drained", 32'(exp_q.size()), 32'd0);
        check("rerun_reads", 32'(re_cnt - re0), 32'd64);

        check("no_re_we_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
